// File: rtl/hex_pkg.sv
// Shared types and constants for the 4-digit hex/BCD entry display.
package hex_pkg;

  localparam int unsigned DIGIT_W    = 4;   // width of one BCD digit
  localparam int unsigned NUM_DIGITS = 4;   // number of display positions
  localparam int unsigned CNT_W      = 3;   // holds 0..NUM_DIGITS
  localparam int unsigned SEG_W      = 7;   // segments a..g
  localparam int unsigned NUM_GLYPHS = 10;  // decimal digits 0..9
  localparam int unsigned MAX_DIGIT  = 9;

  // Entry controller state
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  // Active-low segments, bit 0 = a ... bit 6 = g; all off
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Glyph table, element [n] is the pattern for digit n
  localparam logic [NUM_GLYPHS-1:0][SEG_W-1:0] SEG_TABLE = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Digit to segment pattern; codes above 9 render blank
  function automatic logic [SEG_W-1:0] seg_of(input logic [DIGIT_W-1:0] d);
    logic [SEG_W-1:0] seg;
    seg = SEG_BLANK;
    if (d <= DIGIT_W'(MAX_DIGIT)) begin
      seg = SEG_TABLE[d];
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Single-digit BCD to active-low 7-segment decoder.
module seg7_dec
  import hex_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [SEG_W-1:0]   seg_o
);

  // Pure table lookup
  assign seg_o = seg_of(digit_i);

endmodule

// File: rtl/hex_entry_ctrl.sv
// Four-digit BCD entry shift register with synchronized LOAD/CLEAR
// buttons, error flag, full indication and blinking newest digit.
module hex_entry_ctrl
  import hex_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic [DIGIT_W-1:0] SW,
  input  logic               LOAD,
  input  logic               CLEAR,
  output logic [SEG_W-1:0]   HEX0,
  output logic [SEG_W-1:0]   HEX1,
  output logic [SEG_W-1:0]   HEX2,
  output logic [SEG_W-1:0]   HEX3,
  output logic               FULL,
  output logic               ERR
);

  localparam int unsigned PRESC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // ---------------------------------------------------------------------
  // Button synchronizers and edge detectors
  // ---------------------------------------------------------------------
  logic [1:0] load_sync_q, clr_sync_q;
  logic       load_prev_q, clr_prev_q;
  logic       load_arm_q,  clr_arm_q;
  logic [1:0] sync_vld_q;
  logic       load_arm_d,  clr_arm_d;
  logic       loadp_c, clrp_c;

  // A button is armed only after its settled synchronizer output has been
  // seen low, so a button held through reset never yields an event.
  always_comb begin
    load_arm_d = load_arm_q | (sync_vld_q[1] & ~load_sync_q[1]);
    clr_arm_d  = clr_arm_q  | (sync_vld_q[1] & ~clr_sync_q[1]);
  end

  // Two-flop synchronizers, previous-value flops and arming flags
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      load_sync_q <= '0;
      clr_sync_q  <= '0;
      load_prev_q <= 1'b0;
      clr_prev_q  <= 1'b0;
      load_arm_q  <= 1'b0;
      clr_arm_q   <= 1'b0;
      sync_vld_q  <= '0;
    end else begin
      load_sync_q <= {load_sync_q[0], LOAD};
      clr_sync_q  <= {clr_sync_q[0], CLEAR};
      load_prev_q <= load_sync_q[1];
      clr_prev_q  <= clr_sync_q[1];
      load_arm_q  <= load_arm_d;
      clr_arm_q   <= clr_arm_d;
      sync_vld_q  <= {sync_vld_q[0], 1'b1};
    end
  end

  // One-cycle press events
  assign loadp_c = load_arm_q & load_sync_q[1] & ~load_prev_q;
  assign clrp_c  = clr_arm_q  & clr_sync_q[1]  & ~clr_prev_q;

  // ---------------------------------------------------------------------
  // Digit shift register, count and error flag
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dig_q, dig_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               err_q, err_d;
  logic                               sw_bcd_c;
  logic                               load_ok_c;

  assign sw_bcd_c  = (SW <= DIGIT_W'(MAX_DIGIT));
  // Clear wins over a coincident load; non-BCD loads only raise ERR
  assign load_ok_c = loadp_c & ~clrp_c & sw_bcd_c;

  // Next digits/count/error
  always_comb begin
    dig_d = dig_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (clrp_c) begin
      dig_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (loadp_c) begin
      if (sw_bcd_c) begin
        dig_d = {dig_q[NUM_DIGITS-2:0], SW};
        if (cnt_q != CNT_W'(NUM_DIGITS)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      dig_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      dig_q <= dig_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------
  state_e state_q, state_d;
  logic   full_c;
  logic   enter_full_c;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (load_ok_c) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (clrp_c) begin
          state_d = S_EMPTY;
        end else if (load_ok_c && (cnt_q == CNT_W'(NUM_DIGITS - 1))) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (clrp_c) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State decodes
  always_comb begin
    full_c       = 1'b0;
    enter_full_c = 1'b0;
    if (state_q == S_FULL) begin
      full_c = 1'b1;
    end
    if ((state_q != S_FULL) && (state_d == S_FULL)) begin
      enter_full_c = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Blink prescaler
  // ---------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               phase_q, phase_d;
  logic               blink_c;

  // Restart on every accepted digit, clear and full entry so the digit
  // is always visible first; idle at zero outside S_FULL.
  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    if (clrp_c || load_ok_c || enter_full_c || !full_c) begin
      presc_d = '0;
      phase_d = 1'b0;
    end else if (presc_q == PRESC_W'(BLINK_DIV - 1)) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Prescaler registers
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

  assign blink_c = full_c & phase_q;

  // ---------------------------------------------------------------------
  // Display decode
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_c;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] hex_c;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_disp
    localparam bit IS_NEWEST = (g == 0);

    seg7_dec u_dec (
      .digit_i (dig_q[g]),
      .seg_o   (seg_c[g])
    );

    // Positions beyond the entered count are blank; newest blinks in S_FULL
    assign hex_c[g] = ((CNT_W'(g) < cnt_q) && !(IS_NEWEST && blink_c)) ?
                      seg_c[g] : SEG_BLANK;
  end

  assign HEX0 = hex_c[0];
  assign HEX1 = hex_c[1];
  assign HEX2 = hex_c[2];
  assign HEX3 = hex_c[3];
  assign FULL = full_c;
  assign ERR  = err_q;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Self-checking bench for hex_entry_ctrl: directed scenarios followed by
// random button operations against a queue-based display model.
module tb_hex_entry_ctrl;

  localparam int BDIV = 4;
  localparam logic [6:0] BLANK = 7'h7F;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] sw    = 4'd0;
  logic       load  = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       full, err;

  hex_entry_ctrl #(.BLINK_DIV(BDIV)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SW       (sw),
    .LOAD     (load),
    .CLEAR    (clear),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .FULL     (full),
    .ERR      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Active-low glyphs for 0..9, bit 0 = segment a
  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model: q[0] is the newest digit; anchor is the edge at which the last
  // accepted digit appeared, from which the blink phase follows.
  int q[$];
  bit m_err  = 1'b0;
  int anchor = 0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [6:0] exp_hex(input int n);
    int k;
    if (n >= q.size()) return BLANK;
    k = cyc - anchor;
    if (n == 0 && q.size() == 4 && ((k / BDIV) % 2) == 1) return BLANK;
    return glyph[q[n]];
  endfunction

  task automatic chk(input string tag, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".HEX0"}, hex0, exp_hex(0));
    chk({tag, ".HEX1"}, hex1, exp_hex(1));
    chk({tag, ".HEX2"}, hex2, exp_hex(2));
    chk({tag, ".HEX3"}, hex3, exp_hex(3));
    chk({tag, ".FULL"}, 7'(full), 7'(q.size() == 4));
    chk({tag, ".ERR"},  7'(err),  7'(m_err));
  endtask

  task automatic check_span(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all(tag);
    end
  endtask

  // Press LOAD and/or CLEAR for 'hold' cycles, then release and let it settle.
  // The resulting display change lands on the third edge after the drive.
  task automatic op(input bit do_load, input bit do_clr, input logic [3:0] v, input int hold);
    int c;
    @(negedge clk);
    c     = cyc;
    sw    = v;
    load  = do_load;
    clear = do_clr;
    if (do_clr) begin
      q.delete();
      m_err = 1'b0;
    end else if (do_load) begin
      if (v <= 4'd9) begin
        q.push_front(int'(v));
        if (q.size() > 4) void'(q.pop_back());
        m_err  = 1'b0;
        anchor = c + 3;
      end else begin
        m_err = 1'b1;
      end
    end
    repeat (hold) @(negedge clk);
    load  = 1'b0;
    clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    int blanks;
    int c;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("reset");
    repeat (4) @(negedge clk);

    // Three digits
    op(1, 0, 4'd1, 3);
    op(1, 0, 4'd2, 3);
    op(1, 0, 4'd3, 3);
    check_all("load123");

    // Five digits: wrap and blink
    op(0, 1, 4'd0, 2);
    check_all("clear1");
    for (int d = 1; d <= 5; d++) op(1, 0, 4'(d), 3);
    check_all("load12345");
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_all("blink");
      if (hex0 === BLANK) blanks++;
    end
    chk("blink_count", 7'(blanks), 7'd8);

    // Error flag
    op(0, 1, 4'd0, 2);
    op(1, 0, 4'd7, 3);
    op(1, 0, 4'd12, 3);
    check_all("err_set");
    op(1, 0, 4'd8, 3);
    check_all("err_clr");

    // LOAD and CLEAR together
    op(0, 1, 4'd0, 2);
    op(1, 0, 4'd3, 3);
    op(1, 0, 4'd4, 3);
    op(1, 1, 4'd5, 3);
    check_all("both");

    // Long LOAD hold: one entry, visible within 4 cycles of the rising edge
    @(negedge clk);
    c    = cyc;
    sw   = 4'd6;
    load = 1'b1;
    q.push_front(6);
    m_err  = 1'b0;
    anchor = c + 3;
    repeat (4) @(negedge clk);
    chk("hold_latency", hex0, glyph[6]);
    check_span("hold", 46);
    load = 1'b0;
    check_span("hold_rel", 4);

    // Reset while full and blinking, with LOAD held across it
    for (int d = 1; d <= 4; d++) op(1, 0, 4'(d), 2);
    check_span("pre_rst", 6);
    @(negedge clk);
    sw   = 4'd9;
    load = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_err = 1'b0;
    check_all("mid_rst");
    check_span("rst_hold", 10);
    load = 1'b0;
    check_span("rst_rel", 4);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [3:0] v;
      r = int'($urandom_range(0, 99));
      v = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if (r < 70)      op(1, 0, v, int'($urandom_range(1, 6)));
      else if (r < 82) op(0, 1, v, int'($urandom_range(1, 4)));
      else if (r < 90) op(1, 1, v, int'($urandom_range(1, 4)));
      else             op(1, 0, v, 20);
      check_span("rand", int'($urandom_range(1, 10)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
